// File: rtl/mba_radix4_core.sv
// Sequential radix-4 Modified Booth multiplier: retires two multiplier bits per clock
// and returns the signed double-width product with a one-cycle valid pulse.
module mba_radix4_core #(
  parameter int MBA_SIZE_IN  = 5,
  parameter int MBA_SIZE_OUT = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [MBA_SIZE_IN-1:0]  MBA_A,
  input  logic signed [MBA_SIZE_IN-1:0]  MBA_B,
  input  logic                           MBA_val,
  output logic signed [MBA_SIZE_OUT-1:0] MBA_out,
  output logic                           MBA_out_val,
  output logic                           busy
);

  localparam int unsigned N  = MBA_SIZE_IN;
  localparam int unsigned K  = (N + 1) / 2;
  localparam int unsigned BW = 2 * K;
  localparam int unsigned MW = BW + 1;
  localparam int unsigned PW = N + 2;
  localparam int unsigned AW = 2 * N + 2;
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic signed [N-1:0]    a_reg;
  logic        [MW-1:0]   mreg;
  logic signed [AW-1:0]   acc;
  logic        [CW-1:0]   cnt;

  logic signed [BW-1:0]   b_ext;
  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   pp;
  logic signed [AW-1:0]   pp_sh;
  logic signed [AW-1:0]   sum;

  assign b_ext = BW'(MBA_B);

  // Booth recoding of the lowest triplet, partial product placed at weight 4^cnt
  always_comb begin
    a_ext = PW'(a_reg);
    pp    = '0;
    case (mreg[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext <<< 1;
      3'b100:         pp = -(a_ext <<< 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    pp_sh = AW'(pp) <<< {cnt, 1'b0};
    sum   = acc + pp_sh;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      mreg        <= '0;
      acc         <= '0;
      cnt         <= '0;
      MBA_out     <= '0;
      MBA_out_val <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MBA_val) begin
            a_reg <= MBA_A;
            mreg  <= {b_ext, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          mreg <= mreg >> 2;
          cnt  <= cnt + CW'(1);
          acc  <= sum;
          // Last digit: the truncated sum is exact because the product fits 2N bits
          if (cnt == CW'(K - 1)) begin
            MBA_out     <= sum[MBA_SIZE_OUT-1:0];
            MBA_out_val <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          MBA_out_val <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
